// File: rtl/sound_in.sv
// Sigma-delta receive path: synchronizes the comparator, feeds it back to the RC
// network, decimates the bit stream to 8-bit PCM and derives a hysteresis tape bit.
module sound_in #(
  parameter int unsigned DEC_LOG2 = 8,
  parameter int unsigned HYST     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmp_in,
  output logic       fb_out,
  output logic [7:0] sample,
  output logic       sample_stb,
  output logic       sample_new,
  input  logic       sample_rd,
  output logic       overrun,
  output logic       tape_bit
);

  localparam logic [8:0] TH_HI = 9'(128 + HYST);
  localparam logic [8:0] TH_LO = 9'(128 - HYST);

  logic                sync1;
  logic                cmp_s;
  logic [DEC_LOG2-1:0] win;
  logic [DEC_LOG2:0]   ones;
  logic [DEC_LOG2:0]   total;
  logic [DEC_LOG2-1:0] sat;
  logic [7:0]          next_sample;
  logic                last;

  // A full window of ones reaches 2^DEC_LOG2; clamp so it reads 0xFF, not 0x00.
  always_comb begin
    last        = &win;
    total       = ones + {{DEC_LOG2{1'b0}}, fb_out};
    sat         = total[DEC_LOG2] ? '1 : total[DEC_LOG2-1:0];
    next_sample = sat[DEC_LOG2-1 -: 8];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1      <= 1'b0;
      cmp_s      <= 1'b0;
      fb_out     <= 1'b0;
      win        <= '0;
      ones       <= '0;
      sample     <= '0;
      sample_stb <= 1'b0;
      sample_new <= 1'b0;
      overrun    <= 1'b0;
      tape_bit   <= 1'b0;
    end else begin
      sync1      <= cmp_in;
      cmp_s      <= sync1;
      fb_out     <= cmp_s;
      win        <= win + 1'b1;
      sample_stb <= last;

      if (last) begin
        ones   <= '0;
        sample <= next_sample;
        if ({1'b0, next_sample} >= TH_HI)
          tape_bit <= 1'b1;
        else if ({1'b0, next_sample} < TH_LO)
          tape_bit <= 1'b0;
      end else begin
        ones <= total;
      end

      // A read landing on the strobe edge consumes the old sample, so no overrun.
      if (last) begin
        sample_new <= 1'b1;
        overrun    <= sample_rd ? 1'b0 : (overrun | sample_new);
      end else if (sample_rd) begin
        sample_new <= 1'b0;
        overrun    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sound_in.sv
// Directed bench for sound_in (DEC_LOG2=8, HYST=16): window-aligned comparator
// patterns with hand-computed samples, tape bit and handshake flags.
module tb_sound_in;

  typedef enum logic [1:0] {M_CONST, M_TOG, M_DENS} drive_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmp_in = 1'b0;
  logic       fb_out;
  logic [7:0] sample;
  logic       sample_stb;
  logic       sample_new;
  logic       sample_rd = 1'b0;
  logic       overrun;
  logic       tape_bit;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned ph = 0;      // expected window counter value in the current cycle
  int unsigned stray = 0;   // cycles where the strobe disagreed with the window model
  int unsigned dens_n = 0;
  drive_t      mode = M_CONST;

  sound_in #(.DEC_LOG2(8), .HYST(16)) dut (
    .clk(clk), .reset(reset), .cmp_in(cmp_in), .fb_out(fb_out),
    .sample(sample), .sample_stb(sample_stb), .sample_new(sample_new),
    .sample_rd(sample_rd), .overrun(overrun), .tape_bit(tape_bit)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // cmp_in in window cycle p feeds fb in cycle p+3, so density mode leads by 3.
  task automatic drive_cmp();
    case (mode)
      M_TOG:   cmp_in = ~cmp_in;
      M_DENS:  cmp_in = (((ph + 3) % 256) < dens_n);
      default: ;
    endcase
  endtask

  task automatic tick();
    int unsigned prev_ph;
    logic        r;
    logic        exp_stb;
    prev_ph = ph;
    r = reset;
    @(posedge clk);
    #1;
    exp_stb = !r && (prev_ph == 255);
    ph = r ? 0 : (ph + 1) % 256;
    if (sample_stb !== exp_stb) stray++;
    drive_cmp();
  endtask

  task automatic switch_at_253(input drive_t m, input int unsigned n, input logic lvl);
    while (ph != 253) tick();
    mode = m;
    dens_n = n;
    if (m == M_CONST) cmp_in = lvl;
    else drive_cmp();
  endtask

  task automatic strobe_chk(input string tag, input logic [7:0] exp_s, input logic exp_t,
                            input logic rd_on_edge);
    while (ph != 255) tick();
    sample_rd = rd_on_edge;
    tick();
    sample_rd = 1'b0;
    chk({tag, "_timing"}, stray, 0);
    stray = 0;
    chk({tag, "_stb"}, sample_stb, 1);
    chk({tag, "_sample"}, sample, exp_s);
    chk({tag, "_tape"}, tape_bit, exp_t);
  endtask

  initial begin
    // reset state
    repeat (3) tick();
    chk("rst_fb", fb_out, 0);
    chk("rst_sample", sample, 8'h00);
    chk("rst_stb", sample_stb, 0);
    chk("rst_new", sample_new, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_tape", tape_bit, 0);

    // case 1: cmp_in high from release; fb follows three edges later
    reset = 1'b0;
    cmp_in = 1'b1;
    tick();
    tick();
    chk("fb_lat2", fb_out, 0);
    tick();
    chk("fb_lat3", fb_out, 1);
    strobe_chk("w1", 8'hFD, 1, 0);
    chk("w1_new", sample_new, 1);
    chk("w1_ovr", overrun, 0);
    strobe_chk("w2", 8'hFF, 1, 0);
    chk("w2_new", sample_new, 1);
    chk("w2_ovr", overrun, 1);
    sample_rd = 1'b1;
    tick();
    sample_rd = 1'b0;
    chk("rd_new", sample_new, 0);
    chk("rd_ovr", overrun, 0);
    strobe_chk("w3", 8'hFF, 1, 0);
    chk("w3_new", sample_new, 1);
    chk("w3_ovr", overrun, 0);
    strobe_chk("w4", 8'hFF, 1, 1);
    chk("coinc_new", sample_new, 1);
    chk("coinc_ovr", overrun, 0);

    // case 2: cmp_in low
    switch_at_253(M_CONST, 0, 1'b0);
    strobe_chk("w5", 8'hFF, 1, 0);
    strobe_chk("zero", 8'h00, 0, 0);

    // case 3: toggling input, tape bit held from 0 then from 1
    switch_at_253(M_TOG, 0, 1'b0);
    strobe_chk("w7", 8'h00, 0, 0);
    strobe_chk("tog_from0", 8'h80, 0, 0);
    switch_at_253(M_CONST, 0, 1'b1);
    strobe_chk("w9", 8'h80, 0, 0);
    strobe_chk("w10", 8'hFF, 1, 0);
    switch_at_253(M_TOG, 0, 1'b0);
    strobe_chk("w11", 8'hFF, 1, 0);
    strobe_chk("tog_from1", 8'h80, 1, 0);

    // case 4: hysteresis with exact ones counts per window
    switch_at_253(M_DENS, 0, 1'b0);
    strobe_chk("w13", 8'h80, 1, 0);
    switch_at_253(M_DENS, 143, 1'b0);
    strobe_chk("w14", 8'h00, 0, 0);
    switch_at_253(M_DENS, 144, 1'b0);
    strobe_chk("h143", 8'h8F, 0, 0);
    switch_at_253(M_DENS, 113, 1'b0);
    strobe_chk("h144", 8'h90, 1, 0);
    switch_at_253(M_DENS, 111, 1'b0);
    strobe_chk("h113", 8'h71, 1, 0);
    switch_at_253(M_CONST, 0, 1'b1);
    strobe_chk("h111", 8'h6F, 0, 0);

    // case 6: reset mid-window at count 100
    while (ph != 100) tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_fb", fb_out, 0);
    chk("mid_rst_sample", sample, 8'h00);
    chk("mid_rst_new", sample_new, 0);
    chk("mid_rst_ovr", overrun, 0);
    chk("mid_rst_tape", tape_bit, 0);
    tick();
    tick();
    chk("mid_rst_stb", sample_stb, 0);
    chk("mid_rst_tape3", tape_bit, 0);
    reset = 1'b0;
    strobe_chk("post_rst", 8'hFD, 1, 0);
    chk("post_rst_new", sample_new, 1);
    chk("post_rst_ovr", overrun, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sound_in.md
Name: sound_in

Overview:
- Sigma-delta audio/tape input: the receive-direction counterpart of the 1-bit sound output modulator.
- Pairs with an external comparator and an RC network. The comparator output (cmp_in) is registered and driven back out as the feedback bit (fb_out). The RC filters fb_out, so the ones-density of the bit stream tracks the analog input.
- Block decimates the bit stream into 8-bit unsigned PCM samples, with a read handshake for the port/CPU side.
- Derives a hysteresis-filtered tape-in bit for the tape loader path.

Parameters:
- DEC_LOG2, 8: log2 of the decimation window in clk cycles. Legal range 8..12. At 28 MHz, 8 gives 109.4 kHz sample rate.
- HYST, 16: hysteresis half-width around mid-scale 128, in sample LSBs. Legal range 0..127.

Ports:
- clk  in  1  system clock (28 MHz)
- reset  in  1  synchronous, active-high reset
- cmp_in  in  1  comparator output, asynchronous to clk
- fb_out  out  1  feedback bit to the RC network
- sample  out  8  last decimated sample, unsigned; 0x80 is mid-scale
- sample_stb  out  1  one-cycle pulse when sample updates
- sample_new  out  1  an unread sample is pending
- sample_rd  in  1  one-cycle read acknowledge from port logic
- overrun  out  1  sticky: a sample was overwritten before it was read
- tape_bit  out  1  hysteresis-thresholded tape input

Behaviour:
- Reset: synchronous, active-high. While reset is high, every register clears on each clk edge:
  - sync flops, fb_out, window counter, ones counter
  - sample = 0x00, sample_stb = 0, sample_new = 0, overrun = 0, tape_bit = 0
- Reset mid-window discards the partial count. The window restarts at count 0 in the first cycle after reset falls.
- Input path: 2-flop synchronizer on cmp_in gives cmp_s; fb_out <= cmp_s. Latency from cmp_in to fb_out is 3 edges. The ones counter accumulates fb_out, not cmp_s.
- Window counter: DEC_LOG2 bits, increments every cycle, wraps from all-ones to 0. There is no clock enable; every clk is a modulator step.
- Ones counter: DEC_LOG2+1 bits.
  - Normal cycle: ones <= ones + fb_out.
  - Last window cycle (window counter all-ones): total = ones + fb_out, range 0..2^DEC_LOG2; then ones <= 0.
- Sample conversion:
  - Saturate total to 2^DEC_LOG2 - 1.
  - sample <= saturated total >> (DEC_LOG2 - 8).
  - Example: all-ones window gives 0xFF, not 0x00 after wrap.
- Strobe timing: sample and sample_stb register on the edge ending the last window cycle.
  - sample_stb is high for exactly one cycle.
  - Strobe period is exactly 2^DEC_LOG2 cycles.
  - The first strobe occurs 2^DEC_LOG2 edges after reset release.
- Handshake (evaluated on every edge; sample_rd with no pending sample has no effect):
  - stb and no rd: sample_new <= 1. If sample_new was already 1, overrun <= 1.
  - rd and no stb: sample_new <= 0, overrun <= 0.
  - stb and rd on the same edge: sample_new stays 1 (new sample wins). overrun <= 0, because the old sample was consumed.
- tape_bit: updates on the same edge as sample, evaluated on the new sample value.
  - new sample >= 128 + HYST: tape_bit <= 1.
  - new sample < 128 - HYST: tape_bit <= 0.
  - otherwise: hold.
  - HYST = 0 degenerates to sample[7].
- Arithmetic: all values unsigned. There is no signed conversion in this block; consumers subtract 0x80.

Test Plan (DEC_LOG2=8, HYST=16; stimulus aligned to windows, allowing for the 3-cycle input latency):
1. cmp_in held 1 for 4 windows -> sample=0xFF from the 2nd strobe on; tape_bit=1; sample_stb exactly every 256 clk; fb_out=1 three edges after cmp_in rises.
2. cmp_in held 0 after case 1 -> sample=0x00 after the first full window; tape_bit=0; first strobe 256 clk after reset release.
3. cmp_in toggling every clk -> sample=0x80 every window; tape_bit holds its prior value (checked from both 0 and 1).
4. Hysteresis, windows with exact ones counts from tape_bit=0:
   - 143 -> sample 0x8F, tape_bit stays 0
   - 144 -> 1
   - 113 -> stays 1
   - 111 -> 0
5. Handshake:
   - two strobes with no sample_rd -> sample_new=1, overrun=1
   - sample_rd pulse -> both 0 on the next edge
   - sample_rd coincident with sample_stb -> sample_new=1, overrun=0
6. Reset asserted for 3 clk at window count 100 with cmp_in=1 -> all outputs 0 during reset; next strobe exactly 256 clk after release with sample=0xFF minus sync refill (≥0xFC); no strobe from the aborted window.
